// File: rtl/fft_n64_digit_reorder_if.sv
// Sample stream bundle for the N=64 digit-reverse reorder block.
// xk_index_o exists only when FFT_REORDER_INDEX_EN is defined.
interface fft_n64_digit_reorder_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int W = DATA_WIDTH + 1;

  logic                data_in_valid_i;
  logic                data_in_first_i;
  logic signed [W-1:0] xk_real_i;
  logic signed [W-1:0] xk_imag_i;
  logic                data_out_valid_o;
  logic                frame_first_o;
  logic signed [W-1:0] xk_real_o;
  logic signed [W-1:0] xk_imag_o;
`ifdef FFT_REORDER_INDEX_EN
  logic [5:0]          xk_index_o;

  modport master (
    output data_in_valid_i, data_in_first_i,
    output xk_real_i, xk_imag_i,
    input  data_out_valid_o, frame_first_o,
    input  xk_real_o, xk_imag_o, xk_index_o
  );

  modport slave (
    input  data_in_valid_i, data_in_first_i,
    input  xk_real_i, xk_imag_i,
    output data_out_valid_o, frame_first_o,
    output xk_real_o, xk_imag_o, xk_index_o
  );
`else
  modport master (
    output data_in_valid_i, data_in_first_i,
    output xk_real_i, xk_imag_i,
    input  data_out_valid_o, frame_first_o,
    input  xk_real_o, xk_imag_o
  );

  modport slave (
    input  data_in_valid_i, data_in_first_i,
    input  xk_real_i, xk_imag_i,
    output data_out_valid_o, frame_first_o,
    output xk_real_o, xk_imag_o
  );
`endif
endinterface

// File: rtl/fft_n64_digit_reorder.sv
// Base-4 digit-reversed to natural-order reorder, N=64, ping-pong banks.
// Define FFT_REORDER_INDEX_EN to add the registered xk_index_o output.
module fft_n64_digit_reorder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   sys_clk_i,
  input  logic                   rst_n_i,
  fft_n64_digit_reorder_if.slave bus
);
  localparam int W = DATA_WIDTH + 1;

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  logic [2*W-1:0] mem [128];

  wstate_t        w_state, w_state_n;
  rstate_t        r_state, r_state_n;
  logic [5:0]     wp, wp_n, wp_cur;
  logic [5:0]     rk, rk_n;
  logic           wbank, wbank_n;
  logic           rbank, rbank_n;
  logic [1:0]     ready, set_rdy, clr_rdy;
  logic           we, issue;
  logic [6:0]     waddr, raddr;

  logic           out_valid, out_first;
  logic [W-1:0]   out_real, out_imag;

  always_comb begin
    w_state_n = w_state;
    wp_n      = wp;
    wp_cur    = wp;
    wbank_n   = wbank;
    we        = 1'b0;
    set_rdy   = 2'b00;
    unique case (w_state)
      W_IDLE: begin
        if (bus.data_in_valid_i && bus.data_in_first_i) begin
          we        = 1'b1;
          wp_cur    = 6'd0;
          wp_n      = 6'd1;
          w_state_n = W_FILL;
        end
      end
      W_FILL: begin
        if (bus.data_in_valid_i) begin
          we = 1'b1;
          // A new first restarts the frame in the same bank
          if (bus.data_in_first_i) begin
            wp_cur = 6'd0;
            wp_n   = 6'd1;
          end else if (wp == 6'd63) begin
            set_rdy   = wbank ? 2'b10 : 2'b01;
            wbank_n   = ~wbank;
            wp_n      = 6'd0;
            w_state_n = W_IDLE;
          end else begin
            wp_n = wp + 6'd1;
          end
        end
      end
    endcase
  end

  assign waddr = {wbank, wp_cur[1:0], wp_cur[3:2], wp_cur[5:4]};
  assign raddr = {rbank, rk};

  always_comb begin
    r_state_n = r_state;
    rk_n      = rk;
    rbank_n   = rbank;
    issue     = 1'b0;
    clr_rdy   = 2'b00;
    unique case (r_state)
      R_IDLE: begin
        if (ready[rbank]) begin
          issue     = 1'b1;
          rk_n      = 6'd1;
          r_state_n = R_DRAIN;
        end
      end
      R_DRAIN: begin
        issue = 1'b1;
        rk_n  = rk + 6'd1;
        if (rk == 6'd63) begin
          clr_rdy = rbank ? 2'b10 : 2'b01;
          rbank_n = ~rbank;
          if (!ready[~rbank]) r_state_n = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (we) mem[waddr] <= {bus.xk_real_i, bus.xk_imag_i};
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wp      <= 6'd0;
      rk      <= 6'd0;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      ready   <= 2'b00;
    end else begin
      w_state <= w_state_n;
      r_state <= r_state_n;
      wp      <= wp_n;
      rk      <= rk_n;
      wbank   <= wbank_n;
      rbank   <= rbank_n;
      ready   <= (ready & ~clr_rdy) | set_rdy;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      out_valid <= issue;
      out_first <= issue && (rk == 6'd0);
      if (issue) {out_real, out_imag} <= mem[raddr];
    end
  end

  assign bus.data_out_valid_o = out_valid;
  assign bus.frame_first_o    = out_first;
  assign bus.xk_real_o        = out_real;
  assign bus.xk_imag_o        = out_imag;

`ifdef FFT_REORDER_INDEX_EN
  logic [5:0] out_index;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) out_index <= 6'd0;
    else if (issue) out_index <= rk;
  end

  assign bus.xk_index_o = out_index;
`endif
endmodule

// File: tb/tb_fft_n64_digit_reorder.sv
// Bench for fft_n64_digit_reorder: frame-level model plus directed frames.
// Build with FFT_REORDER_INDEX_EN defined to also check xk_index_o.
module tb_fft_n64_digit_reorder;
  localparam int DW = 32;
  localparam int W  = DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_n64_digit_reorder_if #(.DATA_WIDTH(DW)) bus ();

  fft_n64_digit_reorder #(.DATA_WIDTH(DW)) dut (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int cyc;
    int re;
    int im;
    bit first;
    int k;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_end = 0;
  bit   collecting = 0;
  int   cnt = 0;
  int   fr_re [64];
  int   fr_im [64];

  int   cap_n = 0;
  int   cap_re [256];
  int   cap_im [256];
  int   cap_first [256];
  int   cap_k [256];
  int   cap_cyc [256];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample p lands at bin (p%4)*16 + ((p/4)%4)*4 + p/16; the map is its own inverse
  function automatic int src_of(input int k);
    return (k % 4) * 16 + ((k / 4) % 4) * 4 + k / 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      collecting = 0;
      cnt = 0;
      last_end = 0;
    end else begin
      if (bus.data_in_valid_i) begin
        if (bus.data_in_first_i) begin
          collecting = 1;
          cnt = 0;
        end
        if (collecting) begin
          fr_re[cnt] = int'($signed(bus.xk_real_i));
          fr_im[cnt] = int'($signed(bus.xk_imag_i));
          cnt++;
          if (cnt == 64) begin
            int start;
            collecting = 0;
            start = cyc + 2;
            if (start <= last_end) start = last_end + 1;
            for (int k = 0; k < 64; k++) begin
              exp_t e;
              e.cyc = start + k;
              e.re = fr_re[src_of(k)];
              e.im = fr_im[src_of(k)];
              e.first = (k == 0);
              e.k = k;
              q.push_back(e);
            end
            last_end = start + 63;
          end
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_out_valid_o) begin
        if (cap_n < 256) begin
          cap_re[cap_n] = int'($signed(bus.xk_real_o));
          cap_im[cap_n] = int'($signed(bus.xk_imag_o));
          cap_first[cap_n] = int'(bus.frame_first_o);
`ifdef FFT_REORDER_INDEX_EN
          cap_k[cap_n] = int'(bus.xk_index_o);
`else
          cap_k[cap_n] = 0;
`endif
          cap_cyc[cap_n] = cyc;
        end
        cap_n++;
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("out_real", int'($signed(bus.xk_real_o)), e.re);
          chk("out_imag", int'($signed(bus.xk_imag_o)), e.im);
          chk("out_first", int'(bus.frame_first_o), int'(e.first));
`ifdef FFT_REORDER_INDEX_EN
          chk("out_index", int'(bus.xk_index_o), e.k);
`endif
        end
      end else begin
        chk("idle_first", int'(bus.frame_first_o), 0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("missing_valid", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit v, input bit f, input int re);
    @(posedge clk);
    #1;
    bus.data_in_valid_i = v;
    bus.data_in_first_i = f;
    bus.xk_real_i = W'(re);
    bus.xk_imag_i = W'(-re);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0);
  endtask

  task automatic send_frame(input int base, input bit gap);
    for (int p = 0; p < 64; p++) begin
      drive(1'b1, p == 0, base + p);
      if (gap && p < 63) drive(1'b0, 1'b0, 0);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, int'(bus.data_out_valid_o), 0);
    chk({tag, "_first"}, int'(bus.frame_first_o), 0);
    chk({tag, "_real"}, int'($signed(bus.xk_real_o)), 0);
    chk({tag, "_imag"}, int'($signed(bus.xk_imag_o)), 0);
`ifdef FFT_REORDER_INDEX_EN
    chk({tag, "_index"}, int'(bus.xk_index_o), 0);
`endif
  endtask

  initial begin
    int nfirst;
    bit hit;
    bus.data_in_valid_i = 1'b0;
    bus.data_in_first_i = 1'b0;
    bus.xk_real_i = '0;
    bus.xk_imag_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // single frame
    cap_n = 0;
    send_frame(0, 1'b0);
    idle(70);
    chk("f1_count", cap_n, 64);
    chk("f1_k0", cap_re[0], 0);
    chk("f1_k1", cap_re[1], 16);
    chk("f1_k2", cap_re[2], 32);
    chk("f1_k4", cap_re[4], 4);
    chk("f1_k16", cap_re[16], 1);
    chk("f1_k63", cap_re[63], 63);
    chk("f1_im1", cap_im[1], -16);
    chk("f1_im4", cap_im[4], -4);
    nfirst = 0;
    for (int i = 0; i < 64; i++) nfirst += cap_first[i];
    chk("f1_nfirst", nfirst, 1);
    chk("f1_first0", cap_first[0], 1);
`ifdef FFT_REORDER_INDEX_EN
    chk("f1_idx0", cap_k[0], 0);
    chk("f1_idx37", cap_k[37], 37);
    chk("f1_idx63", cap_k[63], 63);
`endif

    // gapped frame
    cap_n = 0;
    send_frame(0, 1'b1);
    idle(70);
    chk("gap_count", cap_n, 64);
    chk("gap_k2", cap_re[2], 32);
    chk("gap_k16", cap_re[16], 1);

    // back-to-back frames
    cap_n = 0;
    send_frame(100, 1'b0);
    send_frame(200, 1'b0);
    idle(140);
    chk("b2b_count", cap_n, 128);
    chk("b2b_first0", cap_first[0], 1);
    chk("b2b_first64", cap_first[64], 1);
    chk("b2b_span", cap_cyc[127] - cap_cyc[0], 127);
    chk("b2b_k1", cap_re[1], 116);
    chk("b2b_k64", cap_re[64], 200);
    chk("b2b_k80", cap_re[80], 201);

    // aborted partial frame then a full one
    cap_n = 0;
    for (int p = 0; p < 20; p++) drive(1'b1, p == 0, 400 + p);
    send_frame(300, 1'b0);
    idle(70);
    chk("abort_count", cap_n, 64);
    chk("abort_k0", cap_re[0], 300);
    chk("abort_k16", cap_re[16], 301);

    // reset while draining
    cap_n = 0;
    send_frame(500, 1'b0);
    idle(1);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (cap_n == 31) hit = 1;
    end
    chk("rst_reach_bin30", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(80);
    chk("rst_no_output", cap_n, 31);
    send_frame(600, 1'b0);
    idle(70);
    chk("post_rst_count", cap_n, 95);
    chk("post_rst_k0", cap_re[31], 600);
    chk("post_rst_first", cap_first[31], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
